// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TL-UL channel structs and opcodes shared by host and device sides
package tlul_pkg;

   typedef struct packed {
      logic        a_valid;
      logic [2:0]  a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic [15:0] a_user;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      logic [2:0]  d_opcode;
      logic [7:0]  d_source;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

   localparam logic [2:0] PutFullData    = 3'd0;
   localparam logic [2:0] PutPartialData = 3'd1;
   localparam logic [2:0] Get            = 3'd4;
   localparam logic [2:0] AccessAck      = 3'd0;
   localparam logic [2:0] AccessAckData  = 3'd1;

endpackage

// File: rtl/tlul_host_adapter.sv
// rtl/tlul_host_adapter.sv - req/gnt/rvalid master to TL-UL host bridge with in-order response tracking
module tlul_host_adapter #(
   parameter int          MaxReqs    = 2,
   parameter logic [7:0]  SourceBase = 8'h00
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_i,
   output logic                gnt_o,
   input  logic [31:0]         addr_i,
   input  logic                we_i,
   input  logic [31:0]         wdata_i,
   input  logic [3:0]          be_i,
   output logic                rvalid_o,
   output logic [31:0]         rdata_o,
   output logic                rerr_o,
   output tlul_pkg::tl_h2d_t   tl_o,
   input  tlul_pkg::tl_d2h_t   tl_i,
   output logic                busy_o
);

   localparam logic [2:0] MaxCnt  = 3'(MaxReqs);
   localparam logic [1:0] LastIdx = 2'(MaxReqs - 1);

   logic [2:0]  count_q, count_d;
   logic [1:0]  idx_q, idx_d;
   logic [1:0]  wr_ptr_q, wr_ptr_d;
   logic [1:0]  rd_ptr_q, rd_ptr_d;
   logic [7:0]  fifo_src_q [4];
   logic [7:0]  fifo_src_d [4];
   logic        fifo_we_q  [4];
   logic        fifo_we_d  [4];
   logic        rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   logic        rerr_q, rerr_d;
   logic        busy_q, busy_d;

   logic        a_valid, handshake, pop;
   logic [7:0]  a_source;
   logic [2:0]  exp_opcode;
   logic [1:0]  unused_addr;

   function automatic logic [1:0] next_ptr(input logic [1:0] p);
      return (p == LastIdx) ? 2'd0 : p + 2'd1;
   endfunction

   assign unused_addr = addr_i[1:0];
   assign a_valid     = req_i && (count_q < MaxCnt);
   assign handshake   = a_valid && tl_i.a_ready;
   // the count doubles as the FIFO occupancy, so a zero count means a spurious response
   assign pop         = tl_i.d_valid && (count_q != 3'd0);
   assign a_source    = 8'(SourceBase + {6'd0, idx_q});
   assign exp_opcode  = fifo_we_q[rd_ptr_q] ? tlul_pkg::AccessAck : tlul_pkg::AccessAckData;

   always_comb begin
      tl_o           = '0;
      tl_o.a_valid   = a_valid;
      tl_o.a_opcode  = !we_i ? tlul_pkg::Get :
                       (be_i == 4'hF) ? tlul_pkg::PutFullData : tlul_pkg::PutPartialData;
      tl_o.a_size    = 2'd2;
      tl_o.a_source  = a_source;
      tl_o.a_address = {addr_i[31:2], 2'b00};
      tl_o.a_mask    = we_i ? be_i : 4'hF;
      tl_o.a_data    = we_i ? wdata_i : 32'd0;
      tl_o.d_ready   = 1'b1;
   end

   always_comb begin
      idx_d      = idx_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      fifo_src_d = fifo_src_q;
      fifo_we_d  = fifo_we_q;
      count_d    = count_q;
      if (handshake) begin
         fifo_src_d[wr_ptr_q] = a_source;
         fifo_we_d[wr_ptr_q]  = we_i;
         wr_ptr_d             = next_ptr(wr_ptr_q);
         idx_d                = next_ptr(idx_q);
      end
      if (pop) begin
         rd_ptr_d = next_ptr(rd_ptr_q);
      end
      if (handshake && !pop) begin
         count_d = count_q + 3'd1;
      end else if (!handshake && pop) begin
         count_d = count_q - 3'd1;
      end
      rvalid_d = pop;
      rdata_d  = (pop && !fifo_we_q[rd_ptr_q]) ? tl_i.d_data : 32'd0;
      rerr_d   = pop && (tl_i.d_error ||
                         (tl_i.d_source != fifo_src_q[rd_ptr_q]) ||
                         (tl_i.d_opcode != exp_opcode));
      busy_d   = (count_d != 3'd0);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q    <= 3'd0;
         idx_q      <= 2'd0;
         wr_ptr_q   <= 2'd0;
         rd_ptr_q   <= 2'd0;
         fifo_src_q <= '{default: 8'd0};
         fifo_we_q  <= '{default: 1'b0};
         rvalid_q   <= 1'b0;
         rdata_q    <= 32'd0;
         rerr_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         count_q    <= count_d;
         idx_q      <= idx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         fifo_src_q <= fifo_src_d;
         fifo_we_q  <= fifo_we_d;
         rvalid_q   <= rvalid_d;
         rdata_q    <= rdata_d;
         rerr_q     <= rerr_d;
         busy_q     <= busy_d;
      end
   end

   assign gnt_o    = handshake;
   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign rerr_o   = rerr_q;
   assign busy_o   = busy_q;

endmodule

// File: tb/tb_tlul_host_adapter.sv
// tb/tb_tlul_host_adapter.sv - directed self-checking bench for tlul_host_adapter (MaxReqs=2, SourceBase=0)
module tb_tlul_host_adapter;

   logic              clk_i = 1'b0;
   logic              rst_ni;
   logic              req_i;
   logic              gnt_o;
   logic [31:0]       addr_i;
   logic              we_i;
   logic [31:0]       wdata_i;
   logic [3:0]        be_i;
   logic              rvalid_o;
   logic [31:0]       rdata_o;
   logic              rerr_o;
   tlul_pkg::tl_h2d_t tl_o;
   tlul_pkg::tl_d2h_t tl_i;
   logic              busy_o;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_src = 8'd0;
   int rv_count;

   tlul_host_adapter #(.MaxReqs(2), .SourceBase(8'h00)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
      .addr_i(addr_i), .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i),
      .rvalid_o(rvalid_o), .rdata_o(rdata_o), .rerr_o(rerr_o),
      .tl_o(tl_o), .tl_i(tl_i), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic respond(input logic [7:0] src, input logic [2:0] op,
                          input logic [31:0] data, input logic err);
      tl_i.d_valid  = 1'b1;
      tl_i.d_source = src;
      tl_i.d_opcode = op;
      tl_i.d_data   = data;
      tl_i.d_error  = err;
   endtask

   // one request, granted immediately, answered one cycle later
   task automatic txn(input string tag, input logic [31:0] addr, input logic we,
                      input logic [31:0] wdata, input logic [3:0] be,
                      input logic [2:0] exp_op, input logic [3:0] exp_mask,
                      input logic [2:0] d_op, input logic bad_src, input logic d_err,
                      input logic [31:0] d_data, input logic [31:0] exp_rdata,
                      input logic exp_rerr);
      req_i = 1'b1; addr_i = addr; we_i = we; wdata_i = wdata; be_i = be;
      #1;
      check({tag, ".gnt"},    32'(gnt_o), 32'd1);
      check({tag, ".opcode"}, 32'(tl_o.a_opcode), 32'(exp_op));
      check({tag, ".mask"},   32'(tl_o.a_mask), 32'(exp_mask));
      check({tag, ".source"}, 32'(tl_o.a_source), 32'(exp_src));
      step();
      req_i = 1'b0;
      respond(bad_src ? (exp_src ^ 8'd1) : exp_src, d_op, d_data, d_err);
      exp_src = exp_src ^ 8'd1;
      #1;
      check({tag, ".busy"}, 32'(busy_o), 32'd1);
      step();
      tl_i.d_valid = 1'b0;
      check({tag, ".rvalid"}, 32'(rvalid_o), 32'd1);
      check({tag, ".rdata"},  32'(rdata_o), exp_rdata);
      check({tag, ".rerr"},   32'(rerr_o), 32'(exp_rerr));
      check({tag, ".idle"},   32'(busy_o), 32'd0);
   endtask

   initial begin
      rst_ni = 1'b0; req_i = 1'b0; addr_i = '0; we_i = 1'b0; wdata_i = '0; be_i = '0;
      tl_i = '0;
      tl_i.a_ready = 1'b1;
      step(); step();
      check("rst.gnt",     32'(gnt_o), 32'd0);
      check("rst.rvalid",  32'(rvalid_o), 32'd0);
      check("rst.rdata",   rdata_o, 32'd0);
      check("rst.rerr",    32'(rerr_o), 32'd0);
      check("rst.busy",    32'(busy_o), 32'd0);
      check("rst.a_valid", 32'(tl_o.a_valid), 32'd0);
      check("rst.d_ready", 32'(tl_o.d_ready), 32'd1);
      rst_ni = 1'b1;
      step();

      req_i = 1'b1; addr_i = 32'h1000_0007; we_i = 1'b0;
      #1;
      check("rd.address", tl_o.a_address, 32'h1000_0004);
      check("rd.size",    32'(tl_o.a_size), 32'd2);
      check("rd.data",    tl_o.a_data, 32'd0);
      req_i = 1'b0;

      txn("rd",     32'h1000_0007, 1'b0, 32'h0,         4'h0, 3'd4, 4'hF, 3'd1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
      txn("wpart",  32'h2000_0010, 1'b1, 32'h1234_5678, 4'h3, 3'd1, 4'h3, 3'd0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0,         1'b0);
      txn("wfull",  32'h2000_0020, 1'b1, 32'hCAFE_F00D, 4'hF, 3'd0, 4'hF, 3'd0, 1'b0, 1'b0, 32'h0,         32'h0,         1'b0);
      txn("derr",   32'h3000_0000, 1'b0, 32'h0,         4'h0, 3'd4, 4'hF, 3'd1, 1'b0, 1'b1, 32'h1111_2222, 32'h1111_2222, 1'b1);
      txn("badsrc", 32'h3000_0004, 1'b0, 32'h0,         4'h0, 3'd4, 4'hF, 3'd1, 1'b1, 1'b0, 32'h3333_4444, 32'h3333_4444, 1'b1);
      txn("badop",  32'h3000_0008, 1'b1, 32'h5555_6666, 4'hF, 3'd0, 4'hF, 3'd1, 1'b0, 1'b0, 32'h7777_8888, 32'h0,         1'b1);

      // outstanding limit: third request must stall until a response retires one
      req_i = 1'b1; we_i = 1'b0; addr_i = 32'h4000_0000;
      #1;
      check("lim.g0", 32'(gnt_o), 32'd1);
      check("lim.s0", 32'(tl_o.a_source), 32'd0);
      step();
      addr_i = 32'h4000_0004;
      #1;
      check("lim.g1", 32'(gnt_o), 32'd1);
      check("lim.s1", 32'(tl_o.a_source), 32'd1);
      step();
      addr_i = 32'h4000_0008;
      #1;
      check("lim.stall_valid", 32'(tl_o.a_valid), 32'd0);
      check("lim.stall_gnt",   32'(gnt_o), 32'd0);
      check("lim.busy",        32'(busy_o), 32'd1);
      step();
      check("lim.stall2", 32'(tl_o.a_valid), 32'd0);
      respond(8'd0, 3'd1, 32'hAAAA_0000, 1'b0);
      step();
      tl_i.d_valid = 1'b0;
      check("lim.rv0",   32'(rvalid_o), 32'd1);
      check("lim.rd0",   rdata_o, 32'hAAAA_0000);
      check("lim.g2",    32'(gnt_o), 32'd1);
      check("lim.s2",    32'(tl_o.a_source), 32'd0);
      step();
      req_i = 1'b0;
      respond(8'd1, 3'd1, 32'hAAAA_0001, 1'b0);
      step();
      check("lim.rd1",  rdata_o, 32'hAAAA_0001);
      check("lim.err1", 32'(rerr_o), 32'd0);
      respond(8'd0, 3'd1, 32'hAAAA_0002, 1'b0);
      step();
      tl_i.d_valid = 1'b0;
      check("lim.rd2",  rdata_o, 32'hAAAA_0002);
      check("lim.err2", 32'(rerr_o), 32'd0);
      step();
      check("lim.idle", 32'(busy_o), 32'd0);

      // streaming reads: grant and response in the same cycle, count held at 1
      exp_src = 8'd1;
      rv_count = 0;
      for (int i = 0; i < 22; i++) begin
         if (i < 20) begin
            req_i = 1'b1; we_i = 1'b0; addr_i = 32'h5000_0000 + 32'(i * 4);
         end else begin
            req_i = 1'b0;
         end
         if (i > 0) respond(8'((i + 0) % 2), 3'd1, 32'hA000_0000 + 32'(i - 1), 1'b0);
         else       tl_i.d_valid = 1'b0;
         if (i == 21) tl_i.d_valid = 1'b0;
         #1;
         if (i < 20) check($sformatf("str.gnt%0d", i), 32'(gnt_o), 32'd1);
         if (i >= 1 && i <= 20) check($sformatf("str.busy%0d", i), 32'(busy_o), 32'd1);
         if (i >= 2) begin
            if (rvalid_o) rv_count++;
            check($sformatf("str.rd%0d", i - 2), rdata_o, 32'hA000_0000 + 32'(i - 2));
            check($sformatf("str.err%0d", i - 2), 32'(rerr_o), 32'd0);
         end
         step();
      end
      check("str.rv_count", 32'(rv_count), 32'd20);
      check("str.idle", 32'(busy_o), 32'd0);

      // reset with two reads pending; late responses must be dropped
      req_i = 1'b1; addr_i = 32'h6000_0000;
      step();
      addr_i = 32'h6000_0004;
      step();
      req_i = 1'b0;
      #1;
      check("rst2.busy_pre", 32'(busy_o), 32'd1);
      rst_ni = 1'b0;
      #1;
      check("rst2.busy_async", 32'(busy_o), 32'd0);
      step(); step();
      rst_ni = 1'b1;
      step();
      respond(8'd1, 3'd1, 32'hBAD0_0001, 1'b0);
      step();
      check("rst2.rv_a", 32'(rvalid_o), 32'd0);
      respond(8'd0, 3'd1, 32'hBAD0_0000, 1'b0);
      step();
      tl_i.d_valid = 1'b0;
      check("rst2.rv_b", 32'(rvalid_o), 32'd0);
      step();
      check("rst2.rv_c",  32'(rvalid_o), 32'd0);
      check("rst2.busy",  32'(busy_o), 32'd0);
      req_i = 1'b1; addr_i = 32'h7000_0000;
      #1;
      check("rst2.gnt",    32'(gnt_o), 32'd1);
      check("rst2.source", 32'(tl_o.a_source), 32'd0);
      step();
      req_i = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
